// File: rtl/conv_kxk_stream.sv
// Streaming KxK 2-D correlator: line buffers and a sliding window feed a 3-cycle
// multiply / adder-tree / shift-saturate pipeline. The kernel is latched only at frame start.
module conv_kxk_stream #(
    parameter int K        = 3,
    parameter int W        = 320,
    parameter int H        = 240,
    parameter int PIX_W    = 8,
    parameter int COEF_W   = 8,
    parameter int COEF_SGN = 0,
    parameter int SHIFT    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PIX_W-1:0]        in_val,
    input  logic [9:0]              in_x,
    input  logic [9:0]              in_y,
    input  logic                    is_in_val,
    input  logic [K*K*COEF_W-1:0]   kernel,
    output logic [PIX_W-1:0]        out_val,
    output logic [9:0]              out_x,
    output logic [9:0]              out_y,
    output logic                    is_out_val
);

    localparam int R     = (K - 1) / 2;
    localparam int NT    = K * K;
    localparam int XW    = (W > 1) ? $clog2(W) : 1;
    localparam int PRD_W = PIX_W + COEF_W + 1;
    localparam int ACC_W = PIX_W + COEF_W + $clog2(NT) + 1;
    localparam logic [9:0] X_LIM = 10'(W);
    localparam logic [9:0] Y_LIM = 10'(H);
    localparam logic signed [ACC_W-1:0] PIX_MAX =
        $signed({{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}});

    function automatic logic signed [PRD_W-1:0] mul(input logic [PIX_W-1:0] p,
                                                     input logic [COEF_W-1:0] c);
        logic signed [PRD_W-1:0] pe;
        logic signed [PRD_W-1:0] ce;
        pe = $signed({{(PRD_W-PIX_W){1'b0}}, p});
        if (COEF_SGN != 0)
            ce = $signed({{(PRD_W-COEF_W){c[COEF_W-1]}}, c});
        else
            ce = $signed({{(PRD_W-COEF_W){1'b0}}, c});
        return pe * ce;
    endfunction

    function automatic logic signed [ACC_W-1:0] asr(input logic signed [ACC_W-1:0] v);
        return v >>> SHIFT;
    endfunction

    function automatic logic [PIX_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1])
            return '0;
        else if (v > PIX_MAX)
            return '1;
        else
            return v[PIX_W-1:0];
    endfunction

    logic                        w_accept;
    logic                        w_origin;
    logic                        w_emit;
    logic [XW-1:0]               w_xa;
    logic signed [ACC_W-1:0]     w_sum_p1;

    logic                        r_frame_ok;
    logic [K*K*COEF_W-1:0]       r_shadow;
    logic [PIX_W-1:0]            r_lb [0:K-2][0:W-1];
    logic [PIX_W-1:0]            r_win_p0 [0:K-1][0:K-1];
    logic [9:0]                  r_x_p0, r_y_p0, r_x_p1, r_y_p1, r_x_p2, r_y_p2;
    logic                        r_vld_p0, r_vld_p1, r_vld_p2;
    logic signed [PRD_W-1:0]     r_prod_p1 [0:NT-1];
    logic signed [ACC_W-1:0]     r_sum_p2;

    assign w_accept = is_in_val && (in_x < X_LIM) && (in_y < Y_LIM);
    assign w_origin = w_accept && (in_x == 10'd0) && (in_y == 10'd0);
    // The origin pixel enables the frame in the same cycle it is accepted.
    assign w_emit   = w_accept && (r_frame_ok || w_origin) &&
                      (in_x >= 10'(K-1)) && (in_y >= 10'(K-1));
    assign w_xa     = in_x[XW-1:0];

    always_comb begin
        w_sum_p1 = '0;
        for (int t = 0; t < NT; t++)
            w_sum_p1 = w_sum_p1 + {{(ACC_W-PRD_W){r_prod_p1[t][PRD_W-1]}}, r_prod_p1[t]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_ok <= 1'b0;
            r_shadow   <= '0;
            r_vld_p0   <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            is_out_val <= 1'b0;
            out_val    <= '0;
            out_x      <= '0;
            out_y      <= '0;
        end else begin
            if (w_origin) begin
                r_frame_ok <= 1'b1;
                r_shadow   <= kernel;
            end
            r_vld_p0   <= w_emit;
            r_vld_p1   <= r_vld_p0;
            r_vld_p2   <= r_vld_p1;
            is_out_val <= r_vld_p2;
            if (r_vld_p2) begin
                out_val <= sat(r_sum_p2);
                out_x   <= r_x_p2;
                out_y   <= r_y_p2;
            end
        end
    end

    // p0: line-buffer cascade and window shift on each accepted pixel
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 1; r < K - 1; r++)
                r_lb[r][w_xa] <= r_lb[r-1][w_xa];
            r_lb[0][w_xa] <= in_val;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K - 1; j++)
                    r_win_p0[i][j] <= r_win_p0[i][j+1];
            for (int i = 0; i < K - 1; i++)
                r_win_p0[i][K-1] <= r_lb[K-2-i][w_xa];
            r_win_p0[K-1][K-1] <= in_val;
            r_x_p0 <= in_x - 10'(R);
            r_y_p0 <= in_y - 10'(R);
        end
        // p1: per-tap products
        for (int t = 0; t < NT; t++)
            r_prod_p1[t] <= mul(r_win_p0[t / K][t % K],
                                r_shadow[(NT-1-t)*COEF_W +: COEF_W]);
        r_x_p1 <= r_x_p0;
        r_y_p1 <= r_y_p0;
        // p2: adder tree and shift; saturation happens on the output register
        r_sum_p2 <= asr(w_sum_p1);
        r_x_p2   <= r_x_p1;
        r_y_p2   <= r_y_p1;
    end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Bench for conv_kxk_stream: two instances (unsigned SHIFT=4, signed SHIFT=0) share one
// pixel stream; a 2-D correlation model feeds per-instance expectation queues.
module tb_conv_kxk_stream;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int x;
        int y;
        int v;
        int t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_val;
    logic [9:0]  in_x, in_y;
    logic        is_in_val;
    logic [71:0] kern_a, kern_b;
    logic [7:0]  oa_val, ob_val;
    logic [9:0]  oa_x, oa_y, ob_x, ob_y;
    logic        oa_v, ob_v;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nout [2];
    int   mem [H][W];
    int   img [H][W];
    int   shadow [2][9];
    int   coef [2][9];
    bit   fok = 1'b0;
    exp_t q0 [$];
    exp_t q1 [$];
    int   gauss [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int   all2 [9]  = '{default: 2};
    int   lap [9]   = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    int   zk [9]    = '{default: 0};
    int   rk [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_kxk_stream #(.K(3), .W(W), .H(H), .PIX_W(8), .COEF_W(8), .COEF_SGN(0), .SHIFT(4)) u_a (
        .clk(clk), .reset(reset), .in_val(in_val), .in_x(in_x), .in_y(in_y),
        .is_in_val(is_in_val), .kernel(kern_a), .out_val(oa_val), .out_x(oa_x),
        .out_y(oa_y), .is_out_val(oa_v));

    conv_kxk_stream #(.K(3), .W(W), .H(H), .PIX_W(8), .COEF_W(8), .COEF_SGN(1), .SHIFT(0)) u_b (
        .clk(clk), .reset(reset), .in_val(in_val), .in_x(in_x), .in_y(in_y),
        .is_in_val(is_in_val), .kernel(kern_b), .out_val(ob_val), .out_x(ob_x),
        .out_y(ob_y), .is_out_val(ob_v));

    function automatic int interp(input int d, input int c);
        logic [7:0] b;
        b = 8'(c);
        if (d == 1) return int'($signed(b));
        return int'(b);
    endfunction

    function automatic int expv(input int d, input int x, input int y);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += mem[y-2+i][x-2+j] * shadow[d][i*3+j];
        s = s >>> ((d == 0) ? 4 : 0);
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic set_k(input int d, input int c [9]);
        logic [71:0] k;
        k = '0;
        for (int t = 0; t < 9; t++) begin
            coef[d][t] = c[t];
            k[(8-t)*8 +: 8] = 8'(c[t]);
        end
        if (d == 0) kern_a = k;
        else kern_b = k;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input int d, input int v, input int x, input int y);
        exp_t e;
        total++;
        nout[d]++;
        e.x = -1; e.y = -1; e.v = -1; e.t = -1;
        if (d == 0 && q0.size() > 0) e = q0.pop_front();
        if (d == 1 && q1.size() > 0) e = q1.pop_front();
        assert (v === e.v && x === e.x && y === e.y && cyc === e.t) else begin
            bad++;
            $error("FAIL out_dut%0d got (%0d,%0d)=%0d at cyc %0d expected (%0d,%0d)=%0d at cyc %0d",
                   d, x, y, v, cyc, e.x, e.y, e.v, e.t);
        end
    endtask

    task automatic drive(input bit v, input int x, input int y, input int p, input bit rn);
        exp_t e;
        @(negedge clk);
        #1;
        reset = rn; is_in_val = v; in_x = 10'(x); in_y = 10'(y); in_val = 8'(p);
        if (!rn) begin
            q0.delete();
            q1.delete();
            fok = 1'b0;
        end else if (v && x < W && y < H) begin
            mem[y][x] = p;
            if (x == 0 && y == 0) begin
                fok = 1'b1;
                for (int d = 0; d < 2; d++)
                    for (int t = 0; t < 9; t++)
                        shadow[d][t] = interp(d, coef[d][t]);
            end
            if (fok && x >= 2 && y >= 2) begin
                e.x = x - 1; e.y = y - 1; e.t = cyc + 4;
                e.v = expv(0, x, y);
                q0.push_back(e);
                e.v = expv(1, x, y);
                q1.push_back(e);
            end
        end
    endtask

    task automatic drive_px(input int x, input int y, input bit gaps);
        int r;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                r = int'($urandom_range(0, 3));
                if (r == 0) drive(1'b1, W + int'($urandom_range(0, 3)), y, 77, 1'b1);
                else if (r == 1) drive(1'b1, x, H, 77, 1'b1);
                else drive(1'b0, x, y, 33, 1'b1);
            end
        end
        drive(1'b1, x, y, img[y][x], 1'b1);
    endtask

    task automatic rows(input int y0, input int y1, input bit gaps);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < W; x++)
                drive_px(x, y, gaps);
    endtask

    task automatic settle(input string tag);
        repeat (6) drive(1'b0, 0, 0, 0, 1'b1);
        chk({tag, "_drain_a"}, q0.size(), 0);
        chk({tag, "_drain_b"}, q1.size(), 0);
    endtask

    initial begin
        int n0a;
        int n0b;
        nout[0] = 0; nout[1] = 0;
        reset = 1'b0; is_in_val = 1'b0; in_val = '0; in_x = '0; in_y = '0;
        set_k(0, zk);
        set_k(1, zk);
        fork
            forever begin
                @(negedge clk);
                if (oa_v === 1'b1) check_out(0, int'(oa_val), int'(oa_x), int'(oa_y));
                if (ob_v === 1'b1) check_out(1, int'(ob_val), int'(ob_x), int'(ob_y));
            end
        join_none

        repeat (3) drive(1'b0, 0, 0, 0, 1'b0);
        chk("rst_out_val", int'(oa_val), 0);
        chk("rst_out_x", int'(oa_x), 0);
        chk("rst_out_y", int'(oa_y), 0);
        chk("rst_is_out_val_a", int'(oa_v), 0);
        chk("rst_is_out_val_b", int'(ob_v), 0);
        drive(1'b0, 0, 0, 0, 1'b1);

        // constant field: 24 centres, unity-gain blur, saturating all-2 kernel
        foreach (img[y, x]) img[y][x] = 100;
        set_k(0, gauss);
        set_k(1, all2);
        n0a = nout[0]; n0b = nout[1];
        rows(0, H - 1, 1'b0);
        settle("f1");
        chk("f1_count_a", nout[0] - n0a, 24);
        chk("f1_count_b", nout[1] - n0b, 24);

        // impulse response
        foreach (img[y, x]) img[y][x] = 0;
        img[3][3] = 160;
        set_k(1, lap);
        rows(0, H - 1, 1'b0);
        settle("f2");

        // kernel change mid-frame must not take effect until the next origin
        foreach (img[y, x]) img[y][x] = 255;
        set_k(1, all2);
        rows(0, 2, 1'b0);
        set_k(0, zk);
        set_k(1, zk);
        rows(3, H - 1, 1'b0);
        settle("f3");

        // zeroed kernel now live on A; signed Laplacian on B clamps the hole to 0
        foreach (img[y, x]) img[y][x] = 50;
        img[2][3] = 0;
        set_k(1, lap);
        rows(0, H - 1, 1'b0);
        settle("f4");

        // random image and signed kernel, with gaps and out-of-range qualifiers
        foreach (img[y, x]) img[y][x] = int'($urandom_range(0, 255));
        for (int t = 0; t < 9; t++) rk[t] = int'($urandom_range(0, 15)) - 8;
        set_k(0, gauss);
        set_k(1, rk);
        rows(0, H - 1, 1'b1);
        settle("f5g");
        rows(0, H - 1, 1'b0);
        settle("f5");

        // reset mid-frame at (5,3)
        foreach (img[y, x]) img[y][x] = 100;
        rows(0, 2, 1'b0);
        for (int x = 0; x < 5; x++) drive_px(x, 3, 1'b0);
        drive(1'b1, 5, 3, img[3][5], 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_is_out_val_a", int'(oa_v), 0);
        chk("midrst_is_out_val_b", int'(ob_v), 0);
        n0a = nout[0]; n0b = nout[1];
        for (int x = 5; x < W; x++) drive_px(x, 3, 1'b0);
        rows(4, H - 1, 1'b0);
        settle("f6");
        chk("f6_count_a", nout[0] - n0a, 0);
        chk("f6_count_b", nout[1] - n0b, 0);

        // first frame after the reset is filtered with the kernel latched at its origin
        foreach (img[y, x]) img[y][x] = int'($urandom_range(0, 255));
        n0a = nout[0];
        rows(0, H - 1, 1'b0);
        settle("f7");
        chk("f7_count_a", nout[0] - n0a, 24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
